// File: rtl/serializador_paralelo_pkg.sv
// Shared definitions for the parallel-to-serial transmitter.
//   estado_t   : FSM states (idle, shifting, inter-word gap)
//   GAP_CNT_W  : width of the inter-word gap counter (gap range 0..15)
//   bit_cnt_w  : width of the bit counter for a given word length
package serializador_paralelo_pkg;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    DESLOCA   = 2'd1,
    INTERVALO = 2'd2
  } estado_t;

  localparam int unsigned GAP_CNT_W = 4;

  // Bit-counter width is $clog2(WIDTH); WIDTH is a module parameter, so it
  // is derived per instance through this helper.
  function automatic int unsigned bit_cnt_w(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serializador_paralelo.sv
// Parallel-to-serial transmitter feeding a downstream serial-in shift register.
// A WIDTH-bit word is accepted over valido/pronto and shifted out one bit per
// clock on saida; fim flags the cycle holding the last bit, then GAP idle
// cycles (saida = 0) follow before the next word can be taken.
//   clock   : rising-edge clock
//   reset   : asynchronous, active-low
//   dado    : parallel word, sampled on acceptance
//   valido  : producer has a word on dado
//   pronto  : block can accept a word this cycle (from state only)
//   saida   : registered serial data
//   ocupado : word or gap in progress
//   fim     : registered, high while the last bit of a word is on saida
module serializador_paralelo
  import serializador_paralelo_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned GAP       = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] dado,
  input  logic             valido,
  output logic             pronto,
  output logic             saida,
  output logic             ocupado,
  output logic             fim
);

  localparam int unsigned            CNT_W   = bit_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0]       ULTIMO  = CNT_W'(WIDTH - 1);
  localparam logic [GAP_CNT_W-1:0]   GAP_INI = GAP_CNT_W'(GAP);
  localparam logic [GAP_CNT_W-1:0]   GAP_UM  = GAP_CNT_W'(1);

  estado_t              estado, estado_n;
  logic [WIDTH-1:0]     desloc, desloc_n;
  logic [CNT_W-1:0]     cont, cont_n;
  logic [GAP_CNT_W-1:0] cont_gap, cont_gap_n;
  logic                 saida_n, fim_n;
  logic                 ultimo, aceita;

  assign ultimo  = (estado == DESLOCA) && (cont == ULTIMO);
  assign pronto  = (estado == OCIOSO) || ((GAP == 0) && ultimo);
  assign aceita  = valido && pronto;
  assign ocupado = (estado != OCIOSO);

  always_comb begin
    estado_n   = estado;
    desloc_n   = desloc;
    cont_n     = cont;
    cont_gap_n = cont_gap;
    unique case (estado)
      OCIOSO: begin
        if (aceita) begin
          estado_n = DESLOCA;
          desloc_n = dado;
          cont_n   = '0;
        end
      end
      DESLOCA: begin
        if (ultimo) begin
          if (GAP > 0) begin
            estado_n   = INTERVALO;
            cont_gap_n = GAP_INI;
          end else if (aceita) begin
            desloc_n = dado;
            cont_n   = '0;
          end else begin
            estado_n = OCIOSO;
          end
        end else begin
          desloc_n = MSB_FIRST ? {desloc[WIDTH-2:0], 1'b0}
                               : {1'b0, desloc[WIDTH-1:1]};
          cont_n   = cont + 1'b1;
        end
      end
      INTERVALO: begin
        if (cont_gap <= GAP_UM) estado_n = OCIOSO;
        else                    cont_gap_n = cont_gap - 1'b1;
      end
      default: estado_n = OCIOSO;
    endcase
  end

  // saida/fim are registered: compute what they must show in the cycle that
  // follows this edge from the post-edge state, shift register and counter.
  always_comb begin
    saida_n = 1'b0;
    fim_n   = 1'b0;
    if (estado_n == DESLOCA) begin
      saida_n = MSB_FIRST ? desloc_n[WIDTH-1] : desloc_n[0];
      fim_n   = (cont_n == ULTIMO);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado   <= OCIOSO;
      desloc   <= '0;
      cont     <= '0;
      cont_gap <= '0;
      saida    <= 1'b0;
      fim      <= 1'b0;
    end else begin
      estado   <= estado_n;
      desloc   <= desloc_n;
      cont     <= cont_n;
      cont_gap <= cont_gap_n;
      saida    <= saida_n;
      fim      <= fim_n;
    end
  end

endmodule
